// File: rtl/approx_abs_diff_pipe.sv
// ---------------------------------------------------------------------------
// approx_abs_diff_pipe
//
// Purpose:
//   Two-stage pipelined absolute-difference unit. Each operand pair carries
//   its own mode bit.
//   - Exact mode produces |a-b|.
//   - Approximate mode drops DROP_LSB operand LSBs before subtracting and
//     shifts the result back up.
//   The exact result is always computed alongside the approximate one, so the
//   error of every approximate result is known. That error feeds a set of
//   saturating statistics: samples seen, threshold violations and worst-case
//   error.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     operand stream handshake (in_ready is combinational)
//   in_a, in_b            unsigned operands, WIDTH bits
//   in_approx             1 = approximate mode for this pair
//   out_valid/out_ready   result stream handshake
//   out_diff              |a-b|, exact or approximate
//   out_err               |out_diff - exact|, always 0 for exact-mode pairs
//   clr_stats             synchronous clear of all statistics (beats updates)
//   sample_cnt            approximate-mode results produced, saturating
//   viol_cnt              approximate results with err > ET, saturating
//   max_err               largest err since reset or clear
// ---------------------------------------------------------------------------
module approx_abs_diff_pipe #(
  parameter int WIDTH    = 8,
  parameter int DROP_LSB = 2,
  parameter int ET       = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_approx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic [WIDTH-1:0] out_err,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] viol_cnt,
  output logic [WIDTH-1:0] max_err
);

  localparam logic [31:0] ET_L = ET;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_approx;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_diff;
  logic [WIDTH-1:0] s2_err;

  logic             adv1;
  logic             adv2;

  logic [WIDTH-1:0] exact_diff;
  logic [WIDTH-1:0] a_trunc;
  logic [WIDTH-1:0] b_trunc;
  logic [WIDTH-1:0] trunc_diff;
  logic [WIDTH-1:0] approx_diff;
  logic [WIDTH-1:0] approx_err;
  logic [WIDTH-1:0] res_diff;
  logic [WIDTH-1:0] res_err;
  logic             stat_upd;

  // A stage may advance when it is empty or when its content moves on this
  // edge. The input side sees the whole chain combinationally, which gives
  // full throughput with no skid buffer.
  assign adv2     = !s2_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1;

  // The exact and approximate datapaths are both evaluated on the S1
  // contents. The truncated difference never exceeds (2^WIDTH-1)>>DROP_LSB,
  // so shifting it back up cannot overflow WIDTH bits.
  always_comb begin
    exact_diff  = (s1_a >= s1_b) ? (s1_a - s1_b) : (s1_b - s1_a);
    a_trunc     = s1_a >> DROP_LSB;
    b_trunc     = s1_b >> DROP_LSB;
    trunc_diff  = (a_trunc >= b_trunc) ? (a_trunc - b_trunc) : (b_trunc - a_trunc);
    approx_diff = trunc_diff << DROP_LSB;
    approx_err  = (approx_diff >= exact_diff) ? (approx_diff - exact_diff)
                                              : (exact_diff - approx_diff);
    res_diff    = s1_approx ? approx_diff : exact_diff;
    res_err     = s1_approx ? approx_err : '0;
  end

  // Statistics observe the S1->S2 transfer, so each item is counted exactly
  // once, however long it later waits on back-pressure.
  assign stat_upd = adv2 && s1_valid && s1_approx;

  // Stage 1 captures an operand pair whenever it is free to move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_approx <= 1'b0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a      <= in_a;
        s1_b      <= in_b;
        s1_approx <= in_approx;
      end
    end
  end

  // Stage 2 holds the result. Its data is frozen while the output is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_diff  <= '0;
      s2_err   <= '0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_diff <= res_diff;
        s2_err  <= res_err;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_diff  = s2_diff;
  assign out_err   = s2_err;

  // The error monitor uses saturating counters so that a long run can never
  // wrap back to an optimistic value. A clear takes priority over an update
  // arriving on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt <= '0;
      viol_cnt   <= '0;
      max_err    <= '0;
    end else if (clr_stats) begin
      sample_cnt <= '0;
      viol_cnt   <= '0;
      max_err    <= '0;
    end else if (stat_upd) begin
      if (sample_cnt != '1) begin
        sample_cnt <= sample_cnt + CNT_W'(1);
      end
      if ((32'(res_err) > ET_L) && (viol_cnt != '1)) begin
        viol_cnt <= viol_cnt + CNT_W'(1);
      end
      if (res_err > max_err) begin
        max_err <= res_err;
      end
    end
  end

endmodule

// File: tb/tb_approx_abs_diff_pipe.sv
// ---------------------------------------------------------------------------
// tb_approx_abs_diff_pipe
//
// Three instances share every input:
//   u_dut   WIDTH=8, DROP_LSB=2, ET=2, CNT_W=16   main device
//   u_sat   same, but CNT_W=2                     saturation behaviour
//   u_z     same, but DROP_LSB=0                  approx mode must be exact
//
// Expected results come from an arithmetic reference model held in a queue.
// Expected statistics are accumulated when each pair is accepted.
// ---------------------------------------------------------------------------
module tb_approx_abs_diff_pipe;

  localparam int DL  = 2;
  localparam int ETH = 2;

  typedef struct {
    int diff;
    int err;
    int ex;
  } res_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       in_approx;
  logic       out_ready;
  logic       clr_stats;

  logic        in_ready, out_valid;
  logic [7:0]  out_diff, out_err, max_err;
  logic [15:0] sample_cnt, viol_cnt;

  logic        s_in_ready, s_out_valid;
  logic [7:0]  s_out_diff, s_out_err, s_max_err;
  logic [1:0]  s_sample_cnt, s_viol_cnt;

  logic        z_in_ready, z_out_valid;
  logic [7:0]  z_out_diff, z_out_err, z_max_err;
  logic [15:0] z_sample_cnt, z_viol_cnt;

  int   n_checks = 0;
  int   n_fail   = 0;
  res_t exp_q[$];
  int   m_sample, m_viol, m_max;
  int   ms_sample, ms_viol;
  logic last_in_ready, last_out_valid, last_accept;

  always #5 clk = ~clk;

  approx_abs_diff_pipe #(.WIDTH(8), .DROP_LSB(DL), .ET(ETH), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_approx(in_approx), .out_valid(out_valid),
    .out_ready(out_ready), .out_diff(out_diff), .out_err(out_err),
    .clr_stats(clr_stats), .sample_cnt(sample_cnt), .viol_cnt(viol_cnt),
    .max_err(max_err));

  approx_abs_diff_pipe #(.WIDTH(8), .DROP_LSB(DL), .ET(ETH), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_a(in_a), .in_b(in_b), .in_approx(in_approx), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_diff(s_out_diff), .out_err(s_out_err),
    .clr_stats(clr_stats), .sample_cnt(s_sample_cnt), .viol_cnt(s_viol_cnt),
    .max_err(s_max_err));

  approx_abs_diff_pipe #(.WIDTH(8), .DROP_LSB(0), .ET(ETH), .CNT_W(16)) u_z (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(z_in_ready),
    .in_a(in_a), .in_b(in_b), .in_approx(in_approx), .out_valid(z_out_valid),
    .out_ready(out_ready), .out_diff(z_out_diff), .out_err(z_out_err),
    .clr_stats(clr_stats), .sample_cnt(z_sample_cnt), .viol_cnt(z_viol_cnt),
    .max_err(z_max_err));

  // Reference: plain integer arithmetic on the mode rules.
  function automatic res_t model(input int a, input int b, input logic ap);
    res_t r;
    int   at, bt, d;
    r.ex = (a >= b) ? a - b : b - a;
    if (ap) begin
      at     = a / (2 ** DL);
      bt     = b / (2 ** DL);
      d      = ((at >= bt) ? at - bt : bt - at) * (2 ** DL);
      r.diff = d;
      r.err  = (d >= r.ex) ? d - r.ex : r.ex - d;
    end else begin
      r.diff = r.ex;
      r.err  = 0;
    end
    return r;
  endfunction

  task automatic model_clear();
    m_sample  = 0;
    m_viol    = 0;
    m_max     = 0;
    ms_sample = 0;
    ms_viol   = 0;
  endtask

  // One clock cycle: drive on the falling edge, check the settled outputs
  // against the scoreboard, then advance past the rising edge.
  task automatic step(input logic v, input int a, input int b, input logic ap,
                      input logic ordy);
    res_t r;
    @(negedge clk);
    in_valid  = v;
    in_a      = a[7:0];
    in_b      = b[7:0];
    in_approx = ap;
    out_ready = ordy;
    #1;
    last_in_ready  = in_ready;
    last_out_valid = out_valid;
    last_accept    = v && in_ready;
    if (out_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL unexpected_output: out_valid=1 diff=%0d, required no output", out_diff);
      end else begin
        if (out_diff !== exp_q[0].diff) begin
          n_fail++;
          $display("[TB] FAIL out_diff: got %0d required %0d", out_diff, exp_q[0].diff);
        end
        n_checks++;
        if (out_err !== exp_q[0].err) begin
          n_fail++;
          $display("[TB] FAIL out_err: got %0d required %0d", out_err, exp_q[0].err);
        end
        n_checks++;
        if ({z_out_valid, z_out_diff, z_out_err} !== {1'b1, exp_q[0].ex[7:0], 8'd0}) begin
          n_fail++;
          $display("[TB] FAIL drop0_result: got v=%0b d=%0d e=%0d required v=1 d=%0d e=0",
                   z_out_valid, z_out_diff, z_out_err, exp_q[0].ex);
        end
        if (ordy) void'(exp_q.pop_front());
      end
    end
    if (v && in_ready) begin
      r = model(a, b, ap);
      exp_q.push_back(r);
      if (ap) begin
        m_sample++;
        if (r.err > ETH) m_viol++;
        if (r.err > m_max) m_max = r.err;
        if (ms_sample < 3) ms_sample++;
        if (r.err > ETH && ms_viol < 3) ms_viol++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step(1'b0, 0, 0, 1'b0, 1'b1);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_a = 8'd5; in_b = 8'd1; in_approx = 1'b1;
    out_ready = 1'b1; clr_stats = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid, s_out_valid, in_ready} !== 3'b001) begin
      n_fail++;
      $display("[TB] FAIL reset_handshake: out_valid=%0b in_ready=%0b, required 0/1", out_valid, in_ready);
    end
    n_checks++;
    if ({sample_cnt, viol_cnt, max_err, s_sample_cnt, s_viol_cnt} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_stats: got %0d/%0d/%0d, required 0/0/0", sample_cnt, viol_cnt, max_err);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL ready_after_reset: got %0b required 1", in_ready);
    end
  endtask

  task automatic test_exact_latency();
    step(1'b1, 200, 55, 1'b0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL latency_early: out_valid=%0b one edge after accept, required 0", out_valid);
    end
    step(1'b0, 0, 0, 1'b0, 1'b1);
    n_checks++;
    if ({out_valid, out_diff, out_err} !== {1'b1, 8'd145, 8'd0}) begin
      n_fail++;
      $display("[TB] FAIL exact_200_55: v=%0b diff=%0d err=%0d, required 1/145/0", out_valid, out_diff, out_err);
    end
    drain();
    n_checks++;
    if (sample_cnt !== 16'd0) begin
      n_fail++;
      $display("[TB] FAIL exact_no_sample: sample_cnt=%0d required 0", sample_cnt);
    end
  endtask

  task automatic test_approx();
    step(1'b1, 7, 4, 1'b1, 1'b1);
    step(1'b1, 4, 3, 1'b1, 1'b1);
    drain();
    n_checks++;
    if ({sample_cnt, viol_cnt, max_err} !== {16'd2, 16'd2, 8'd3}) begin
      n_fail++;
      $display("[TB] FAIL approx_stats: got %0d/%0d/%0d, required 2/2/3", sample_cnt, viol_cnt, max_err);
    end
    n_checks++;
    if (z_viol_cnt !== 16'd0 || z_max_err !== 8'd0) begin
      n_fail++;
      $display("[TB] FAIL drop0_stats: viol=%0d max=%0d, required 0/0", z_viol_cnt, z_max_err);
    end
  endtask

  task automatic test_back_to_back();
    step(1'b1, 10, 3, 1'b0, 1'b0);
    step(1'b1, 3, 10, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 9, 9, 1'b0, 1'b0);
      n_checks++;
      if (last_in_ready !== 1'b0 || last_accept !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL stall_ready: in_ready=%0b, required 0", last_in_ready);
      end
    end
    step(1'b1, 9, 9, 1'b0, 1'b1);
    n_checks++;
    if (last_accept !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL release_accept: accepted=%0b, required 1", last_accept);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 0, 0, 1'b0, 1'b1);
      n_checks++;
      if (last_out_valid !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL back_to_back: out_valid=%0b in drain cycle %0d, required 1", last_out_valid, i);
      end
    end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7));
    end
    drain();
    n_checks++;
    if (sample_cnt !== m_sample[15:0] || viol_cnt !== m_viol[15:0] || max_err !== m_max[7:0]) begin
      n_fail++;
      $display("[TB] FAIL random_stats: got %0d/%0d/%0d, required %0d/%0d/%0d",
               sample_cnt, viol_cnt, max_err, m_sample, m_viol, m_max);
    end
    n_checks++;
    if (s_sample_cnt !== ms_sample[1:0] || s_viol_cnt !== ms_viol[1:0]) begin
      n_fail++;
      $display("[TB] FAIL random_sat_stats: got %0d/%0d, required %0d/%0d",
               s_sample_cnt, s_viol_cnt, ms_sample, ms_viol);
    end
    n_checks++;
    if (z_viol_cnt !== 16'd0 || z_max_err !== 8'd0 || z_sample_cnt !== m_sample[15:0]) begin
      n_fail++;
      $display("[TB] FAIL drop0_random: viol=%0d max=%0d samples=%0d, required 0/0/%0d",
               z_viol_cnt, z_max_err, z_sample_cnt, m_sample);
    end
  endtask

  task automatic test_saturation_clear();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b1, 7, 4, 1'b1, 1'b1);
    drain();
    n_checks++;
    if (s_sample_cnt !== ms_sample[1:0] || s_viol_cnt !== ms_viol[1:0] || s_sample_cnt !== 2'd3) begin
      n_fail++;
      $display("[TB] FAIL saturation: got %0d/%0d, required %0d/%0d",
               s_sample_cnt, s_viol_cnt, ms_sample, ms_viol);
    end
    n_checks++;
    if (sample_cnt !== m_sample[15:0] || viol_cnt !== m_viol[15:0]) begin
      n_fail++;
      $display("[TB] FAIL wide_count: got %0d/%0d, required %0d/%0d", sample_cnt, viol_cnt, m_sample, m_viol);
    end
    step(1'b1, 7, 4, 1'b1, 1'b1);
    clr_stats = 1'b1;
    step(1'b0, 0, 0, 1'b0, 1'b1);
    clr_stats = 1'b0;
    model_clear();
    n_checks++;
    if ({sample_cnt, viol_cnt, max_err, s_sample_cnt, s_viol_cnt, s_max_err} !== '0) begin
      n_fail++;
      $display("[TB] FAIL clear_wins: got %0d/%0d/%0d sat %0d/%0d, required all 0",
               sample_cnt, viol_cnt, max_err, s_sample_cnt, s_viol_cnt);
    end
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL clear_keeps_data: out_valid=%0b, required 1", out_valid);
    end
    drain();
  endtask

  task automatic test_reset_midstream();
    step(1'b1, 20, 5, 1'b0, 1'b0);
    step(1'b1, 30, 1, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL async_flush: out_valid=%0b in_ready=%0b, required 0/1", out_valid, in_ready);
    end
    exp_q.delete();
    model_clear();
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 0, 0, 1'b0, 1'b1);
      n_checks++;
      if (last_out_valid !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL stale_result: out_valid=%0b diff=%0d after reset, required 0", last_out_valid, out_diff);
      end
    end
  endtask

  initial begin
    test_reset();
    test_exact_latency();
    test_approx();
    test_back_to_back();
    test_random();
    test_saturation_clear();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
